// File: rtl/fetch_unit.sv
// fetch_unit
// ----------
// Instruction-fetch stage. Owns the architectural PC, issues one request at a
// time to instruction memory, and presents the fetched word to the datapath.
// Fetch and execute alternate (IDLE -> REQ -> EXEC -> ...), so at most one
// instruction is ever in flight.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a redirect to a target with bits [1:0] != 0 sets the sticky
//               misalign_o flag, loads the raw target into the PC and parks the
//               FSM in IDLE until rst.
//   undefined : redirect targets are word-aligned by clearing bits [1:0];
//               misalign_o is tied low.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   fetch_stall_i   hold the current instruction and freeze the PC
//   pc_sel_i        next-PC select (NONE / ADD4 / JMP; other codes = NONE)
//   br_taken_i      taken branch, redirect to next_pc_i
//   next_pc_i       redirect target
//   imem_req_o      memory request (high for the whole REQ state)
//   imem_addr_o     request address, always equal to pc_o
//   imem_ack_i      memory response valid, data on imem_rdata_i same cycle
//   imem_rdata_i    instruction word
//   ir_o            current instruction
//   pc_o            PC of the current or pending instruction
//   ir_valid_o      ir_o valid for execution this cycle (EXEC state)
//   fetch_count_o   number of accepted fetches (wraps)
//   misalign_o      sticky misaligned-target flag
module fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          SEL_PC_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fetch_stall_i,
    input  logic [SEL_PC_WIDTH-1:0] pc_sel_i,
    input  logic                    br_taken_i,
    input  logic [31:0]             next_pc_i,
    output logic                    imem_req_o,
    output logic [31:0]             imem_addr_o,
    input  logic                    imem_ack_i,
    input  logic [31:0]             imem_rdata_i,
    output logic [31:0]             ir_o,
    output logic [31:0]             pc_o,
    output logic                    ir_valid_o,
    output logic [31:0]             fetch_count_o,
    output logic                    misalign_o
);

    // Next-PC select codes (shared encoding with the control block).
    localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_NONE = SEL_PC_WIDTH'(0);
    localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_ADD4 = SEL_PC_WIDTH'(1);
    localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_JMP  = SEL_PC_WIDTH'(2);

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_EXEC = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_n;
    logic [31:0] pc_r;
    logic [31:0] pc_n;
    logic [31:0] ir_r;
    logic [31:0] ir_n;
    logic [31:0] count_r;
    logic [31:0] count_n;
    logic        req_r;
    logic        valid_r;
    logic        sel_add4;
    logic        sel_jmp;
    logic        locked;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_r;
    logic        misalign_n;
`endif

    // Decode the select code; unknown codes fall through as NONE.
    always_comb begin
        sel_add4 = 1'b0;
        sel_jmp  = 1'b0;
        case (pc_sel_i)
            SEL_PC_ADD4: sel_add4 = 1'b1;
            SEL_PC_JMP:  sel_jmp  = 1'b1;
            SEL_PC_NONE: sel_add4 = 1'b0;
            default:     sel_jmp  = 1'b0;
        endcase
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    assign locked = misalign_r;
`else
    assign locked = 1'b0;
`endif

    // Next-state and next-value logic for the fetch FSM and its registers.
    always_comb begin
        state_n = state_r;
        pc_n    = pc_r;
        ir_n    = ir_r;
        count_n = count_r;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_n = misalign_r;
`endif
        case (state_r)
            ST_IDLE: begin
                // A trapped misaligned redirect parks the stage here until rst.
                if (!locked && !fetch_stall_i && (sel_add4 || sel_jmp)) begin
                    state_n = ST_REQ;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_REQ: begin
                // Stall never cancels an outstanding request.
                if (imem_ack_i) begin
                    ir_n    = imem_rdata_i;
                    count_n = count_r + 32'd1;
                    state_n = ST_EXEC;
                end else begin
                    state_n = ST_REQ;
                end
            end
            ST_EXEC: begin
                if (fetch_stall_i) begin
                    state_n = ST_EXEC;
                end else if (br_taken_i || sel_jmp) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    pc_n = next_pc_i;
                    if (next_pc_i[1:0] != 2'b00) begin
                        misalign_n = 1'b1;
                        state_n    = ST_IDLE;
                    end else begin
                        state_n = ST_REQ;
                    end
`else
                    pc_n    = next_pc_i & 32'hFFFF_FFFC;
                    state_n = ST_REQ;
`endif
                end else if (sel_add4) begin
                    pc_n    = pc_r + 32'd4;
                    state_n = ST_REQ;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; request/valid flags are registered
    // copies of the next-state decode so no input reaches an output
    // combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            pc_r    <= RESET_PC;
            ir_r    <= NOP_INSN;
            count_r <= 32'd0;
            req_r   <= 1'b0;
            valid_r <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_r <= 1'b0;
`endif
        end else begin
            state_r <= state_n;
            pc_r    <= pc_n;
            ir_r    <= ir_n;
            count_r <= count_n;
            req_r   <= (state_n == ST_REQ);
            valid_r <= (state_n == ST_EXEC);
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_r <= misalign_n;
`endif
        end
    end

    assign imem_req_o    = req_r;
    assign imem_addr_o   = pc_r;
    assign pc_o          = pc_r;
    assign ir_o          = ir_r;
    assign ir_valid_o    = valid_r;
    assign fetch_count_o = count_r;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign_o    = misalign_r;
`else
    assign misalign_o    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by a
// randomized run, all compared against a behavioural model of the fetch
// stage held in this module.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        fetch_stall_i;
    logic [1:0]  pc_sel_i;
    logic        br_taken_i;
    logic [31:0] next_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] ir_o;
    logic [31:0] pc_o;
    logic        ir_valid_o;
    logic [31:0] fetch_count_o;
    logic        misalign_o;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(RST_PC), .SEL_PC_WIDTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_stall_i (fetch_stall_i),
        .pc_sel_i      (pc_sel_i),
        .br_taken_i    (br_taken_i),
        .next_pc_i     (next_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .ir_o          (ir_o),
        .pc_o          (pc_o),
        .ir_valid_o    (ir_valid_o),
        .fetch_count_o (fetch_count_o),
        .misalign_o    (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // The stage is either waiting for a fetch to be started ("idle"),
    // waiting for memory ("fetching"), or presenting an instruction
    // ("holding").
    bit          m_fetching;
    bit          m_holding;
    bit          m_trapped;
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic [31:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_fetching = 1'b0;
        m_holding  = 1'b0;
        m_trapped  = 1'b0;
        m_pc       = RST_PC;
        m_ir       = 32'h0000_0013;
        m_cnt      = 32'd0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_clock();
        bit wants_fetch;
        bit redirect;
        if (rst) begin
            model_reset();
        end else if (m_fetching) begin
            if (imem_ack_i) begin
                m_ir       = imem_rdata_i;
                m_cnt      = m_cnt + 32'd1;
                m_fetching = 1'b0;
                m_holding  = 1'b1;
            end
        end else if (m_holding) begin
            if (!fetch_stall_i) begin
                redirect  = br_taken_i || (pc_sel_i == 2'd2);
                m_holding = 1'b0;
                if (redirect) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    m_pc = next_pc_i;
                    if ((next_pc_i % 32'd4) != 32'd0) m_trapped = 1'b1;
                    else                               m_fetching = 1'b1;
`else
                    m_pc       = next_pc_i - (next_pc_i % 32'd4);
                    m_fetching = 1'b1;
`endif
                end else if (pc_sel_i == 2'd1) begin
                    m_pc       = m_pc + 32'd4;
                    m_fetching = 1'b1;
                end
            end
        end else begin
            wants_fetch = (pc_sel_i == 2'd1) || (pc_sel_i == 2'd2);
            if (wants_fetch && !fetch_stall_i && !m_trapped) m_fetching = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".req"},   {31'd0, imem_req_o}, {31'd0, m_fetching});
        chk({tag, ".addr"},  imem_addr_o, m_pc);
        chk({tag, ".pc"},    pc_o, m_pc);
        chk({tag, ".ir"},    ir_o, m_ir);
        chk({tag, ".valid"}, {31'd0, ir_valid_o}, {31'd0, m_holding});
        chk({tag, ".cnt"},   fetch_count_o, m_cnt);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk({tag, ".mis"},   {31'd0, misalign_o}, {31'd0, m_trapped});
`else
        chk({tag, ".mis"},   {31'd0, misalign_o}, 32'd0);
`endif
    endtask

    // One clock: called at a negedge, drives inputs, steps model, checks
    // outputs at the following negedge.
    task automatic cyc(input string tag, input logic r, input logic st,
                       input logic [1:0] sel, input logic br, input logic [31:0] npc,
                       input logic ack, input logic [31:0] rd);
        rst           = r;
        fetch_stall_i = st;
        pc_sel_i      = sel;
        br_taken_i    = br;
        next_pc_i     = npc;
        imem_ack_i    = ack;
        imem_rdata_i  = rd;
        model_clock();
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    int valid_seen;

    initial begin
        rst = 1'b1; fetch_stall_i = 1'b0; pc_sel_i = 2'd0; br_taken_i = 1'b0;
        next_pc_i = 32'd0; imem_ack_i = 1'b0; imem_rdata_i = 32'd0;
        model_reset();
        @(negedge clk);
        cyc("rst0", 1'b1, 1'b0, 2'd0, 1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF);
        cyc("rst1", 1'b1, 1'b0, 2'd1, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("reset_pc", pc_o, 32'h0000_0100);
        chk("reset_ir", ir_o, 32'h0000_0013);
        chk("reset_req", {31'd0, imem_req_o}, 32'd0);

        // Zero-wait fetch from RESET_PC.
        cyc("none", 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        cyc("go", 1'b0, 1'b0, 2'd1, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("t1_addr", imem_addr_o, 32'h0000_0100);
        chk("t1_req", {31'd0, imem_req_o}, 32'd1);
        cyc("ack0", 1'b0, 1'b0, 2'd1, 1'b0, 32'd0, 1'b1, 32'h0050_0093);
        chk("t1_ir", ir_o, 32'h0050_0093);
        chk("t1_valid", {31'd0, ir_valid_o}, 32'd1);
        cyc("seq", 1'b0, 1'b0, 2'd1, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("t1_next", imem_addr_o, 32'h0000_0104);
        chk("t1_cnt", fetch_count_o, 32'd1);

        // Ack delayed three cycles.
        valid_seen = 0;
        for (int i = 0; i < 3; i++) begin
            cyc("wait", 1'b0, 1'b1, 2'd0, 1'b0, 32'd0, 1'b0, 32'd0);
            chk("t2_req_stable", {31'd0, imem_req_o}, 32'd1);
            chk("t2_addr_stable", imem_addr_o, 32'h0000_0104);
            if (ir_valid_o) valid_seen++;
        end
        cyc("ack3", 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 1'b1, 32'h0000_1111);
        if (ir_valid_o) valid_seen++;
        cyc("toidle", 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        if (ir_valid_o) valid_seen++;
        chk("t2_valid_once", valid_seen, 32'd1);

        // Branch redirect.
        cyc("f", 1'b0, 1'b0, 2'd1, 1'b0, 32'd0, 1'b0, 32'd0);
        cyc("a", 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 1'b1, 32'h0000_2222);
        cyc("br", 1'b0, 1'b0, 2'd0, 1'b1, 32'h0000_0200, 1'b0, 32'd0);
        chk("t3_br_addr", imem_addr_o, 32'h0000_0200);

        // Stall for 5 EXEC cycles with a pending jump.
        cyc("a", 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 1'b1, 32'h0000_3333);
        for (int i = 0; i < 5; i++) begin
            cyc("stall", 1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0300, 1'b1, 32'h0000_9999);
            chk("t4_valid", {31'd0, ir_valid_o}, 32'd1);
            chk("t4_pc", pc_o, 32'h0000_0200);
            chk("t4_ir", ir_o, 32'h0000_3333);
        end
        cyc("jmp", 1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0300, 1'b0, 32'd0);
        chk("t4_jmp_addr", imem_addr_o, 32'h0000_0300);

        // Reset mid-request, then a late ack.
        cyc("rstreq", 1'b1, 1'b0, 2'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("t5_req", {31'd0, imem_req_o}, 32'd0);
        cyc("late", 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 1'b1, 32'h0000_4444);
        chk("t5_cnt", fetch_count_o, 32'd0);
        chk("t5_ir", ir_o, 32'h0000_0013);

        // Misaligned redirect.
        cyc("f", 1'b0, 1'b0, 2'd1, 1'b0, 32'd0, 1'b0, 32'd0);
        cyc("a", 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 1'b1, 32'h0000_5555);
        cyc("mis", 1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0202, 1'b0, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("t6_mis", {31'd0, misalign_o}, 32'd1);
        chk("t6_pc", pc_o, 32'h0000_0202);
        cyc("stuck", 1'b0, 1'b0, 2'd1, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("t6_stuck", {31'd0, imem_req_o}, 32'd0);
`else
        chk("t6_addr", imem_addr_o, 32'h0000_0200);
        chk("t6_req", {31'd0, imem_req_o}, 32'd1);
`endif
        cyc("rst", 1'b1, 1'b0, 2'd0, 1'b0, 32'd0, 1'b0, 32'd0);

        // Randomized run.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] npc;
            npc = $urandom;
            if ($urandom_range(0, 3) != 0) npc[1:0] = 2'b00;
            cyc("rand",
                ($urandom_range(0, 199) == 0),
                ($urandom_range(0, 3) == 0),
                2'($urandom_range(0, 3)),
                ($urandom_range(0, 7) == 0),
                npc,
                ($urandom_range(0, 1) == 1),
                $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage sitting directly downstream of the core control block: consumes its gated `pc_sel`, `br_taken`, `next_pc` and `fetch_stall` outputs. It owns the architectural PC register, runs a request/acknowledge handshake to instruction memory, and presents the fetched instruction word (`ir_o`) with a valid flag to the datapath for execution. Fetch and execute alternate, so there are never two instructions in flight.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `fetch_stall_i` input 1: hold the current instruction and freeze the PC.
- `pc_sel_i` input `SEL_PC_WIDTH`: next-PC select, with codes from `param_pc_mux.vh`:
  - `SEL_PC_NONE`: hold.
  - `SEL_PC_ADD4`: sequential.
  - `SEL_PC_JMP`: redirect.
- `br_taken_i` input 1: taken branch; redirect to `next_pc_i`.
- `next_pc_i` input 32: redirect target.
- `imem_req_o` output 1: memory request.
- `imem_addr_o` output 32: request address, equal to `pc_o`.
- `imem_ack_i` input 1: memory response valid; data on `imem_rdata_i` in the same cycle.
- `imem_rdata_i` input 32: instruction word.
- `ir_o` output 32: current instruction.
- `pc_o` output 32: PC of the current or pending instruction.
- `ir_valid_o` output 1: `ir_o` is valid for execution this cycle.
- `fetch_count_o` output 32: number of accepted fetches.
- `misalign_o` output 1: sticky misaligned-target flag (see Configuration).

## Operation
- FSM states are IDLE, REQ and EXEC.
- IDLE:
  - No request is issued.
  - Go to REQ when `pc_sel_i != SEL_PC_NONE` and `!fetch_stall_i`.
- REQ:
  - `imem_req_o = 1`; `imem_addr_o = pc_o`, held stable until ack.
  - When `imem_ack_i` is high: register `imem_rdata_i` into `ir_o`, increment `fetch_count_o` (wraps at 2^32), go to EXEC.
  - `fetch_stall_i` does not cancel an outstanding request.
- EXEC:
  - `ir_valid_o = 1`.
  - If `fetch_stall_i` is high: stay in EXEC, with PC and IR unchanged.
  - Otherwise update the PC and move on. Priority order:
    - `br_taken_i` or `SEL_PC_JMP`: PC <= `next_pc_i`, go to REQ.
    - `SEL_PC_ADD4`: PC <= PC + 4 (32-bit, wraps at 32'hFFFF_FFFC to 0), go to REQ.
    - `SEL_PC_NONE`: PC held, go to IDLE.
- Any code other than those three is treated as `SEL_PC_NONE`.
- `imem_ack_i` is ignored in IDLE and EXEC. A late ack after reset is dropped.

## Timing
- Reset values:
  - `pc_o = RESET_PC`
  - `ir_o = 32'h0000_0013` (NOP)
  - `ir_valid_o = 0`, `imem_req_o = 0`
  - `fetch_count_o = 0`, `misalign_o = 0`
  - FSM in IDLE.
- All outputs are registered or decoded from the FSM state only. There is no combinational path from `imem_ack_i` to any output.
- Best case is 2 cycles per instruction: REQ with ack in the same cycle, then EXEC.
- Each extra memory wait cycle adds one cycle in REQ.
- `rst` asserted in any state: all outputs return to their reset values on the next edge. `imem_req_o` drops after that edge, even mid-handshake.
- Stall and redirect in the same EXEC cycle: the stall wins, and the redirect is re-evaluated on the next unstalled cycle.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A redirect target with `next_pc_i[1:0] != 0` sets `misalign_o` (sticky), loads the unmodified target into `pc_o`, and forces the FSM to IDLE.
  - The FSM then stays in IDLE regardless of `pc_sel_i` until `rst`.
- Not defined:
  - The redirect target has bits [1:0] forced to 0.
  - `misalign_o` is tied to 0.

## Test plan
- Reset release with `RESET_PC = 32'h100`, `SEL_PC_NONE` for one cycle, then `SEL_PC_ADD4`, zero-wait ack with rdata `32'h00500093`:
  - `imem_addr_o = 32'h100`.
  - `ir_o = 32'h00500093` with `ir_valid_o` high one cycle later.
  - Next request at `32'h104`; `fetch_count_o = 1`.
- Ack delayed 3 cycles:
  - `imem_req_o` and `imem_addr_o` are stable for 4 cycles.
  - `ir_valid_o` is asserted exactly once, and only after the ack.
- In EXEC: `br_taken_i = 1`, `next_pc_i = 32'h200` → next request address is `32'h200`.
- `fetch_stall_i` high for 5 EXEC cycles together with `SEL_PC_JMP`:
  - `ir_valid_o` stays high; `pc_o` and `ir_o` are unchanged.
  - Redirect occurs on the first unstalled cycle.
- `rst` pulsed while in REQ, followed by an ack:
  - `imem_req_o` is 0 after the reset edge.
  - The ack is ignored; `fetch_count_o = 0`; `ir_o = 32'h13`.
- Redirect to `32'h202`:
  - Macro defined: `misalign_o = 1`, FSM stuck in IDLE.
  - Macro undefined: request at `32'h200`.
